// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine for the execute stage.
// One operation in flight; 32-step shift-add multiply or restoring divide,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            is_m,
  input  logic            is_d,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            fin,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_f3;
  logic [31:0] r_b;
  logic [63:0] r_prod;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic        r_neg_rem;
  logic [31:0] r_result;

  logic        w_start;
  logic        w_is_div;
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_fast;
  logic [31:0] w_fast_val;
  logic [32:0] w_madd;
  logic [63:0] w_mul_next;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_div_next;
  logic [63:0] w_iter;
  logic [63:0] w_prod_s;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  // Start decode, operand sign handling and fast-path detection on live inputs
  always_comb begin
    w_start    = (is_m | is_d) & ~flush;
    w_is_div   = funct3[2];
    // mult: a signed unless MULHU, b signed for MUL/MULH; div: signed for DIV/REM
    w_a_sgn    = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    w_b_sgn    = w_is_div ? ~funct3[0] : ~funct3[1];
    w_a_neg    = w_a_sgn & src1[31];
    w_b_neg    = w_b_sgn & src2[31];
    w_a_mag    = w_a_neg ? (~src1 + 32'd1) : src1;
    w_b_mag    = w_b_neg ? (~src2 + 32'd1) : src2;
    w_div_zero = w_is_div & (src2 == 32'd0);
    w_div_ovf  = w_is_div & ~funct3[0] & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
    w_fast     = w_div_zero | w_div_ovf;
    if (w_div_zero) begin
      w_fast_val = funct3[1] ? src1 : 32'hFFFF_FFFF;
    end else begin
      w_fast_val = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step: r_prod holds {acc, multiplier} or {remainder, quotient}
  always_comb begin
    w_madd     = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_b} : 33'd0);
    w_mul_next = {w_madd, r_prod[31:1]};
    // the shifted partial remainder is 33 bits; its low 32 bits of the
    // difference are exact whenever the subtraction does not borrow
    w_ge       = ({1'b0, r_prod[63:31]} >= {2'b00, r_b});
    w_sub      = r_prod[62:31] - r_b;
    if (w_ge) begin
      w_div_next = {w_sub, r_prod[30:0], 1'b1};
    end else begin
      w_div_next = {r_prod[62:0], 1'b0};
    end
    w_iter     = r_f3[2] ? w_div_next : w_mul_next;
  end

  // Sign correction and result selection from the final iteration value
  always_comb begin
    w_prod_s = r_neg ? (~w_iter + 64'd1) : w_iter;
    w_quot   = r_neg ? (~w_iter[31:0] + 32'd1) : w_iter[31:0];
    w_rem    = r_neg_rem ? (~w_iter[63:32] + 32'd1) : w_iter[63:32];
    case (r_f3)
      3'b000:  w_final = w_prod_s[31:0];
      3'b001,
      3'b010,
      3'b011:  w_final = w_prod_s[63:32];
      3'b100,
      3'b101:  w_final = w_quot;
      3'b110,
      3'b111:  w_final = w_rem;
      default: w_final = 32'd0;
    endcase
  end

  // Next-state logic; a request seen in DONE belongs to the finishing instruction
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = w_fast ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == 5'd0) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture, iteration datapath, counter and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_f3      <= 3'd0;
      r_b       <= 32'd0;
      r_prod    <= 64'd0;
      r_cnt     <= 5'd0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_f3      <= funct3;
            r_b       <= w_b_mag;
            r_prod    <= {32'd0, w_a_mag};
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            if (w_fast) begin
              r_result <= w_fast_val;
            end else begin
              r_cnt <= 5'd31;
            end
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_prod <= w_iter;
            if (r_cnt == 5'd0) begin
              r_result <= w_final;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fin    = (r_state == S_DONE);
  assign busy   = (r_state == S_RUN);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven checks of muldiv_unit plus
// hand-written sequences for flush, back-to-back and asynchronous reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        is_m;
  logic        is_d;
  logic [2:0]  funct3;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        fin;
  logic        busy;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        both;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .is_m   (is_m),
    .is_d   (is_d),
    .funct3 (funct3),
    .src1   (src1),
    .src2   (src2),
    .flush  (flush),
    .fin    (fin),
    .busy   (busy),
    .result (result)
  );

  // free-running clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic both);
    funct3 = f3;
    src1   = a;
    src2   = b;
    is_m   = both | ~f3[2];
    is_d   = both | f3[2];
    flush  = 1'b0;
  endtask

  // Call at a negedge with the request driven; the next posedge is the start edge.
  // Returns the cycle offset of fin (or -1 on timeout) and the number of busy cycles.
  task automatic wait_fin(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) begin
        src1   = $urandom;
        src2   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
      if (busy) bcnt++;
      if (fin) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [31:0] prev;

    vecs[0]  = '{3'b000, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b001, 1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'b010, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'b011, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[4]  = '{3'b100, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 1'b1, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'b111, 1'b0, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'b101, 1'b0, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b110, 1'b0, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'b100, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'b110, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'b100, 1'b0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
    vecs[13] = '{3'b001, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vecs[14] = '{3'b100, 1'b0, 32'd0,          32'd0,         32'hFFFF_FFFF, 1};

    rstn = 1'b0; is_m = 1'b0; is_d = 1'b0; flush = 1'b0;
    funct3 = 3'd0; src1 = 32'd0; src2 = 32'd0;
    step();
    step();
    chk("reset fin",    32'(fin),  32'd0);
    chk("reset busy",   32'(busy), 32'd0);
    chk("reset result", result,    32'd0);
    rstn = 1'b1;
    step();

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].both);
      wait_fin(lat, bcnt);
      chk($sformatf("v%0d result", i), result, vecs[i].exp);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d busy cycles", i), 32'(bcnt), (vecs[i].lat == 1) ? 32'd0 : 32'd32);
      is_m = 1'b0;
      is_d = 1'b0;
      step();
      chk($sformatf("v%0d fin after", i), 32'(fin), 32'd0);
    end
    prev = vecs[14].exp;

    // flush in RUN: MUL starts in N, flush in N+10, DIVU 9/3 requested in N+11
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    step();                          // now in N+1
    bcnt = 0;
    for (int c = 2; c <= 10; c++) begin
      if (fin) bcnt++;
      step();
    end
    if (fin) bcnt++;
    chk("flush busy in N+10", 32'(busy), 32'd1);
    flush = 1'b1;
    is_m  = 1'b0;
    step();                          // now in N+11
    if (fin) bcnt++;
    chk("flush no fin", 32'(bcnt), 32'd0);
    chk("flush busy N+11", 32'(busy), 32'd0);
    chk("flush result kept", result, prev);
    issue(3'b101, 32'd9, 32'd3, 1'b0);
    wait_fin(lat, bcnt);
    chk("post-flush DIVU result", result, 32'd3);
    chk("post-flush DIVU latency", 32'(lat), 32'd33);
    is_d = 1'b0;
    step();

    // back-to-back: is_m held through fin, next MUL presented right after
    issue(3'b000, 32'd3, 32'd5, 1'b0);
    wait_fin(lat, bcnt);
    chk("b2b first result", result, 32'd15);
    chk("b2b first latency", 32'(lat), 32'd33);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step();                          // cycle after fin: IDLE, start edge next
    chk("b2b one fin", 32'(fin), 32'd0);
    chk("b2b idle busy", 32'(busy), 32'd0);
    wait_fin(lat, bcnt);
    chk("b2b second result", result, 32'd1);
    chk("b2b second latency", 32'(lat), 32'd33);
    is_m = 1'b0;
    step();

    // flush together with a request in IDLE: no start
    issue(3'b000, 32'd2, 32'd2, 1'b0);
    flush = 1'b1;
    bcnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (busy | fin) bcnt++;
    end
    chk("idle flush no start", 32'(bcnt), 32'd0);
    is_m  = 1'b0;
    flush = 1'b0;
    step();

    // asynchronous reset mid-RUN
    issue(3'b101, 32'd100, 32'd7, 1'b0);
    for (int c = 0; c < 5; c++) step();
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async reset busy",   32'(busy), 32'd0);
    chk("async reset fin",    32'(fin),  32'd0);
    chk("async reset result", result,    32'd0);
    is_d = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    issue(3'b111, 32'd100, 32'd7, 1'b0);
    wait_fin(lat, bcnt);
    chk("post-reset REMU result", result, 32'd2);
    chk("post-reset REMU latency", 32'(lat), 32'd33);
    is_d = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
